i2c_target: RTL

I2C target (slave) endpoint, 7-bit addressing, standard/fast mode, no clock stretching. Bus sequence is address, subaddress, then data bytes, the same frame format the team's I2C master issues. Each received data byte becomes a register-write strobe; each read byte is fetched through a register-read strobe. The block sits between the open-drain SB_IO pins and a small register file or peripheral control bank, in the same `sys_clock` domain.

---
 rtl/i2c_target.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/i2c_target.sv
// I2C target endpoint: 7-bit address, subaddress pointer, register strobes.
// Deglitched SCL/SDA inputs; open-drain SDA through sda_oe; no clock stretching.
module i2c_target #(
  parameter logic [6:0] ADDR = 7'h3C,
  parameter int         FILT = 4
) (
  input  logic       sys_clock,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_ACK    = 3'd2;
  localparam logic [2:0] S_SUB    = 3'd3;
  localparam logic [2:0] S_WDATA  = 3'd4;
  localparam logic [2:0] S_RDATA  = 3'd5;
  localparam logic [2:0] S_RACK   = 3'd6;
  localparam logic [2:0] S_IGNORE = 3'd7;

  logic [FILT-1:0] scl_taps, sda_taps;
  logic            scl_f, sda_f, scl_p, sda_p;
  logic            scl_rise, scl_fall, start_c, stop_c;
  logic [2:0]      state, ack_next;
  logic            ack_inc, ack_drv, rack_ok, load_pend;
  logic [3:0]      bit_cnt;
  logic [6:0]      shift, tx;
  logic [7:0]      rx_byte;
  logic            byte_done;

  // Filtered level moves only when every tap agrees; idle bus level is 1.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      scl_taps <= '1;
      sda_taps <= '1;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_p    <= 1'b1;
      sda_p    <= 1'b1;
    end else begin
      scl_taps <= {scl_taps[FILT-2:0], scl_in};
      sda_taps <= {sda_taps[FILT-2:0], sda_in};
      if (&scl_taps)       scl_f <= 1'b1;
      else if (~|scl_taps) scl_f <= 1'b0;
      if (&sda_taps)       sda_f <= 1'b1;
      else if (~|sda_taps) sda_f <= 1'b0;
      scl_p <= scl_f;
      sda_p <= sda_f;
    end
  end

  assign scl_rise  = scl_f & ~scl_p;
  assign scl_fall  = ~scl_f & scl_p;
  assign start_c   = scl_f & sda_p & ~sda_f;
  assign stop_c    = scl_f & ~sda_p & sda_f;
  assign rx_byte   = {shift, sda_f};
  assign byte_done = scl_rise && (bit_cnt == 4'd7);

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state     <= S_IDLE;
      ack_next  <= S_IDLE;
      ack_inc   <= 1'b0;
      ack_drv   <= 1'b0;
      rack_ok   <= 1'b0;
      load_pend <= 1'b0;
      bit_cnt   <= 4'd0;
      shift     <= 7'd0;
      tx        <= 7'd0;
      sda_oe    <= 1'b0;
      reg_addr  <= 8'd0;
      reg_wdata <= 8'd0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle; later non-blocking writes in this block win.
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      load_pend <= reg_rd;
      if (stop_c) begin
        state     <= S_IDLE;
        busy      <= 1'b0;
        sda_oe    <= 1'b0;
        load_pend <= 1'b0;
      end else if (start_c) begin
        state     <= S_ADDR;
        bit_cnt   <= 4'd0;
        sda_oe    <= 1'b0;
        load_pend <= 1'b0;
      end else begin
        if (scl_rise) begin
          shift   <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 4'd1;
        end
        case (state)
          S_ADDR: if (byte_done) begin
            if (rx_byte[7:1] == ADDR && ADDR != 7'd0) begin
              state    <= S_ACK;
              busy     <= 1'b1;
              ack_next <= rx_byte[0] ? S_RDATA : S_SUB;
              ack_inc  <= 1'b0;
              ack_drv  <= 1'b0;
            end else begin
              state <= S_IGNORE;
              busy  <= 1'b0;
            end
          end
          S_SUB: if (byte_done) begin
            reg_addr <= rx_byte;
            state    <= S_ACK;
            ack_next <= S_WDATA;
            ack_inc  <= 1'b0;
            ack_drv  <= 1'b0;
          end
          S_WDATA: if (byte_done) begin
            reg_wdata <= rx_byte;
            reg_wr    <= 1'b1;
            state     <= S_ACK;
            ack_next  <= S_WDATA;
            ack_inc   <= 1'b1;
            ack_drv   <= 1'b0;
          end
          // First fall starts the ACK pulse, second fall ends it and enters the next byte.
          S_ACK: if (scl_fall) begin
            if (!ack_drv) begin
              sda_oe  <= 1'b1;
              ack_drv <= 1'b1;
            end else begin
              sda_oe  <= 1'b0;
              state   <= ack_next;
              bit_cnt <= 4'd0;
              reg_rd  <= (ack_next == S_RDATA);
              if (ack_inc) reg_addr <= reg_addr + 8'd1;
            end
          end
          S_RDATA: begin
            if (load_pend) begin
              tx     <= reg_rdata[6:0];
              sda_oe <= ~reg_rdata[7];
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe  <= 1'b0;
                state   <= S_RACK;
                rack_ok <= 1'b0;
              end else begin
                sda_oe <= ~tx[6];
                tx     <= {tx[5:0], 1'b0};
              end
            end
          end
          S_RACK: begin
            if (scl_rise) begin
              if (!sda_f) begin
                reg_addr <= reg_addr + 8'd1;
                rack_ok  <= 1'b1;
              end else begin
                state <= S_IGNORE;
                busy  <= 1'b0;
              end
            end else if (scl_fall && rack_ok) begin
              reg_rd  <= 1'b1;
              bit_cnt <= 4'd0;
              state   <= S_RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
